// File: rtl/adc16dv160_input_common_pkg.sv
// Shared constants and types for the ADC input core AXI-Lite register blocks.
package adc16dv160_input_common;

  localparam logic [3:0] AXI_OFS_CR    = 4'h0;
  localparam logic [3:0] AXI_OFS_SR    = 4'h4;
  localparam logic [3:0] AXI_OFS_DSIZE = 4'h8;
  localparam logic [3:0] AXI_OFS_ID    = 4'hC;

  localparam logic [31:0] AXI_CR_TEST = 32'h0000_0001;
  localparam logic [31:0] AXI_CR_RT   = 32'h0000_0002;
  localparam logic [31:0] AXI_SR_PC   = 32'h0000_0001;
  localparam logic [31:0] AXI_SR_OVR  = 32'h0000_0002;

  localparam int CH_STRIDE = 16;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DECODE, RESP} axi_rd_state_t;

endpackage

// File: rtl/adc16dv160_input_axi_rd_decode.sv
// Combinational read mux: latched address plus per-channel status gives read data,
// error flag and a one-hot marker of which channel's SR an OKAY read targets.
module adc16dv160_input_axi_rd_decode
  import adc16dv160_input_common::*;
#(
  parameter int          NUM_CH  = 2,
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] ID_CODE = 16'hADC1
) (
  input  logic [ADDR_W-1:0]   addr_q,
  input  logic [NUM_CH*32-1:0] dsize,
  input  logic [NUM_CH-1:0]   cr_test,
  input  logic [NUM_CH-1:0]   cr_rt,
  input  logic [NUM_CH-1:0]   sr_pc,
  input  logic [NUM_CH-1:0]   ovr,
  output logic [31:0]         rdata,
  output logic                err,
  output logic [NUM_CH-1:0]   sr_hit_ch
);

  localparam int CH_W = ADDR_W - 4;

  logic [CH_W-1:0] ch;
  assign ch = addr_q[ADDR_W-1:4];

  always_comb begin
    rdata     = '0;
    sr_hit_ch = '0;
    err       = (addr_q[1:0] != 2'b00) || (32'(ch) >= NUM_CH);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!err && (32'(ch) == k)) begin
        case (addr_q[3:0])
          AXI_OFS_CR:    rdata = (cr_test[k] ? AXI_CR_TEST : '0) | (cr_rt[k] ? AXI_CR_RT : '0);
          AXI_OFS_SR: begin
            rdata        = (sr_pc[k] ? AXI_SR_PC : '0) | (ovr[k] ? AXI_SR_OVR : '0);
            sr_hit_ch[k] = 1'b1;
          end
          AXI_OFS_DSIZE: rdata = dsize[32*k +: 32];
          AXI_OFS_ID:    rdata = {ID_CODE, 8'(NUM_CH), 8'(ch)};
          default:       rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/adc16dv160_input_axi_rd_regs.sv
// Multi-channel AXI4-Lite read channel for the ADC input core (CR/SR/DSIZE/ID per channel).
// Define ADC_AXI_RD_STICKY_OVR_EN for sticky, clear-on-read SR.OVR flags.
module adc16dv160_input_axi_rd_regs
  import adc16dv160_input_common::*;
#(
  parameter int          NUM_CH  = 2,
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] ID_CODE = 16'hADC1
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [31:0]          ARADDR,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [31:0]          RDATA,
  output logic [1:0]           RRESP,
  output logic                 RVALID,
  input  logic                 RREADY,
  input  logic [NUM_CH*32-1:0] dsize,
  input  logic [NUM_CH-1:0]    cr_test,
  input  logic [NUM_CH-1:0]    cr_rt,
  input  logic [NUM_CH-1:0]    sr_pc,
  input  logic [NUM_CH-1:0]    sr_ovr
);

  axi_rd_state_t       state;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         dec_rdata;
  logic                dec_err;
  logic [NUM_CH-1:0]   sr_hit_ch;
  logic [NUM_CH-1:0]   ovr_sel;

  // Address bits above the decoded window are deliberately ignored.
  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^ARADDR[31:ADDR_W];
  end

  adc16dv160_input_axi_rd_decode #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .ID_CODE (ID_CODE)
  ) u_decode (
    .addr_q    (addr_q),
    .dsize     (dsize),
    .cr_test   (cr_test),
    .cr_rt     (cr_rt),
    .sr_pc     (sr_pc),
    .ovr       (ovr_sel),
    .rdata     (dec_rdata),
    .err       (dec_err),
    .sr_hit_ch (sr_hit_ch)
  );

`ifdef ADC_AXI_RD_STICKY_OVR_EN
  logic [NUM_CH-1:0] ovr_q;

  // Clear happens after the DECODE snapshot; a coincident set keeps the flag.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= (ovr_q & ~((state == DECODE) ? sr_hit_ch : '0)) | sr_ovr;
    end
  end

  assign ovr_sel = ovr_q;
`else
  logic unused_sr_hit;
  assign unused_sr_hit = ^sr_hit_ch;
  assign ovr_sel       = sr_ovr;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state   <= IDLE;
      addr_q  <= '0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RRESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          ARREADY <= 1'b1;
          if (ARVALID && ARREADY) begin
            addr_q  <= ARADDR[ADDR_W-1:0];
            ARREADY <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          RDATA  <= dec_rdata;
          RRESP  <= dec_err ? RRESP_SLVERR : RRESP_OKAY;
          RVALID <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (RVALID && RREADY) begin
            RVALID  <= 1'b0;
            RDATA   <= '0;
            ARREADY <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc16dv160_input_axi_rd_regs.sv
// Scoreboard bench for adc16dv160_input_axi_rd_regs: directed map/handshake cases, random reads, reset drop.
module tb_adc16dv160_input_axi_rd_regs;

  localparam int          NUM_CH  = 2;
  localparam int          ADDR_W  = 8;
  localparam logic [15:0] ID_CODE = 16'hADC1;

  logic                 ACLK = 1'b0;
  logic                 ARESETN;
  logic [31:0]          ARADDR;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [31:0]          RDATA;
  logic [1:0]           RRESP;
  logic                 RVALID;
  logic                 RREADY;
  logic [NUM_CH*32-1:0] dsize;
  logic [NUM_CH-1:0]    cr_test;
  logic [NUM_CH-1:0]    cr_rt;
  logic [NUM_CH-1:0]    sr_pc;
  logic [NUM_CH-1:0]    sr_ovr;

  adc16dv160_input_axi_rd_regs #(
    .NUM_CH (NUM_CH), .ADDR_W (ADDR_W), .ID_CODE (ID_CODE)
  ) dut (
    .ACLK (ACLK), .ARESETN (ARESETN), .ARADDR (ARADDR), .ARVALID (ARVALID),
    .ARREADY (ARREADY), .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID),
    .RREADY (RREADY), .dsize (dsize), .cr_test (cr_test), .cr_rt (cr_rt),
    .sr_pc (sr_pc), .sr_ovr (sr_ovr)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t              q[$];
  exp_t              mon_e;
  int                checks = 0;
  int                errors = 0;
  logic [NUM_CH-1:0] flag_m = '0;
  logic              prev_rv = 1'b0;
  logic [31:0]       held_d;
  logic [1:0]        held_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of one read from the register map, using current bench inputs.
  function automatic exp_t model(input logic [31:0] addr);
    exp_t              e;
    int                a, ch, ofs;
    logic [NUM_CH-1:0] ovr_now;
    a = int'(addr % (32'd1 << ADDR_W));
    ch = a / 16;
    ofs = a % 16;
`ifdef ADC_AXI_RD_STICKY_OVR_EN
    ovr_now = flag_m | sr_ovr;
`else
    ovr_now = sr_ovr;
`endif
    e.addr = addr;
    e.data = 32'h0;
    e.resp = 2'b10;
    if ((ofs % 4 == 0) && (ch < NUM_CH)) begin
      e.resp = 2'b00;
      case (ofs / 4)
        0:       e.data = {30'd0, cr_rt[ch], cr_test[ch]};
        1:       e.data = {30'd0, ovr_now[ch], sr_pc[ch]};
        2:       e.data = dsize[32*ch +: 32];
        default: e.data = (32'(ID_CODE) << 16) | 32'(NUM_CH * 256 + ch);
      endcase
    end
    return e;
  endfunction

  // Sticky flag bookkeeping: inputs are held through the whole read.
  task automatic post_update(input logic [31:0] addr);
    int a, ch, ofs;
    a = int'(addr % (32'd1 << ADDR_W));
    ch = a / 16;
    ofs = a % 16;
    flag_m = flag_m | sr_ovr;
    if (ofs == 4 && ch < NUM_CH && !sr_ovr[ch]) flag_m[ch] = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int delay, input bit pulse_dec);
    int cnt;
    @(posedge ACLK); #1;
    ARADDR  = addr;
    ARVALID = 1'b1;
    cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARREADY) break;
      cnt++;
      if (cnt > 20) break;
    end
    if (!ARREADY) begin
      checks++;
      errors++;
      $display("FAIL arready_timeout: got ARREADY=0 expected 1 within 20 cycles");
      ARVALID = 1'b0;
      return;
    end
    q.push_back(model(addr));
    post_update(addr);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    if (pulse_dec) sr_ovr[0] = 1'b1;
    if (delay == 0 && $urandom_range(0, 1) == 1) RREADY = 1'b1;
    @(negedge ACLK);
    chk("lat_n1_rvalid", 32'(RVALID), 32'd0);
    @(posedge ACLK); #1;
    if (pulse_dec) begin
      sr_ovr[0] = 1'b0;
      flag_m[0] = 1'b1;
    end
    if (delay == 0) RREADY = 1'b1;
    @(negedge ACLK);
    chk("lat_n2_rvalid", 32'(RVALID), 32'd1);
    for (int i = 0; i < delay; i++) begin
      @(posedge ACLK); #1;
      dsize = {$urandom, $urandom};
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(negedge ACLK);
    chk("arready_return", 32'(ARREADY), 32'd1);
    chk("rvalid_drop", 32'(RVALID), 32'd0);
  endtask

  // Monitor: response stability and scoreboard pop on each R handshake.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_rv = 1'b0;
    end else begin
      if (RVALID && !prev_rv) begin
        held_d = RDATA;
        held_r = RRESP;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: got RVALID=1 expected no response pending");
        end
      end else if (RVALID) begin
        chk("hold_rdata", RDATA, held_d);
        chk("hold_rresp", 32'(RRESP), 32'(held_r));
      end
      if (RVALID && RREADY && q.size() > 0) begin
        mon_e = q.pop_front();
        chk("rdata", RDATA, mon_e.data);
        chk("rresp", 32'(RRESP), 32'(mon_e.resp));
      end
      prev_rv = RVALID;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200us");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [31:0] addr;
    ARESETN = 1'b0;
    ARADDR  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    dsize   = '0;
    cr_test = '0;
    cr_rt   = '0;
    sr_pc   = '0;
    sr_ovr  = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", 32'(RRESP), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("arready_pre_rise", 32'(ARREADY), 32'd0);
    @(negedge ACLK);
    chk("arready_rise", 32'(ARREADY), 32'd1);

    dsize = {32'hCAFE_0001, 32'h0000_1234};
    do_read(32'h08, 0, 1'b0);
    cr_test = 2'b10;
    cr_rt   = 2'b10;
    do_read(32'h10, 0, 1'b0);
    do_read(32'h1C, 1, 1'b0);
    do_read(32'h20, 0, 1'b0);
    do_read(32'h06, 0, 1'b0);
    do_read(32'h18, 5, 1'b0);

`ifdef ADC_AXI_RD_STICKY_OVR_EN
    sr_pc = '0;
    do_read(32'h04, 0, 1'b0);
    @(posedge ACLK); #1;
    sr_ovr[0] = 1'b1;
    @(posedge ACLK); #1;
    sr_ovr[0] = 1'b0;
    flag_m[0] = 1'b1;
    do_read(32'h04, 0, 1'b0);
    do_read(32'h04, 0, 1'b0);
    do_read(32'h04, 0, 1'b1);
    do_read(32'h04, 0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      dsize   = {$urandom, $urandom};
      cr_test = NUM_CH'($urandom);
      cr_rt   = NUM_CH'($urandom);
      sr_pc   = NUM_CH'($urandom);
      sr_ovr  = NUM_CH'($urandom);
      addr    = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 47));
      do_read(addr, int'($urandom_range(0, 3)), 1'b0);
    end
    sr_ovr = '0;

    // Reset while a response is pending: it must be dropped.
    @(posedge ACLK); #1;
    ARADDR  = 32'h08;
    ARVALID = 1'b1;
    cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARREADY || cnt > 20) break;
      cnt++;
    end
    q.push_back(model(32'h08));
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("rst_pre_rvalid", 32'(RVALID), 32'd1);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    q.delete();
    flag_m = '0;
    @(negedge ACLK);
    chk("rst_mid_rvalid", 32'(RVALID), 32'd0);
    chk("rst_mid_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    RREADY  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("no_resp_after_rst", 32'(RVALID), 32'd0);
    end
    RREADY = 1'b0;
    do_read(32'h0C, 0, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
